// File: rtl/mmio_pkg.sv
// mmio_pkg: AXI response codes and bridge FSM state shared by the MMIO bridge files.
package mmio_pkg;
    typedef enum logic [1:0] {
        AXI_RESP_OKAY,
        AXI_RESP_EXOKAY,
        AXI_RESP_SLVERR,
        AXI_RESP_DECERR
    } axi_resp_t;
    typedef enum logic [2:0] {IDLE, WR_ACC, WR_RESP, RD_ACC, RD_RESP} state_t;
endpackage

// File: rtl/axil_mmio_bridge_if.sv
// axil_mmio_bridge_if: AXI4-Lite bus bundle with master and slave views.
interface axil_mmio_bridge_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   awaddr;
    logic [2:0]          awprot;
    logic                awvalid, awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid, wready;
    logic [1:0]          bresp;
    logic                bvalid, bready;
    logic [ADDR_W-1:0]   araddr;
    logic [2:0]          arprot;
    logic                arvalid, arready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid, rready;
    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready, araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready, araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axil_rr_arb2.sv
// axil_rr_arb2: two-requester arbiter; priority flips to the other requester after each grant.
module axil_rr_arb2 (
    input  logic       clk,
    input  logic       arst_n,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);
    logic ptr;
    assign gnt[0] = en & req[0] & (~req[1] | ~ptr);
    assign gnt[1] = en & req[1] & (~req[0] | ptr);
    always_ff @(posedge clk or negedge arst_n)
        if (!arst_n) ptr <= 1'b0;
        else if (|gnt) ptr <= gnt[0];
endmodule

// File: rtl/axil_mmio_bridge.sv
// axil_mmio_bridge: AXI4-Lite slave serving one transaction at a time on N_SLOTS MMIO slots.
// Define AXIL_MMIO_TIMEOUT_EN to abort slot accesses after TIMEOUT_CYC cycles with SLVERR.
module axil_mmio_bridge
    import mmio_pkg::*;
#(
    parameter int N_SLOTS     = 16,
    parameter int ADDR_W      = 12,
    parameter int REG_ADDR_W  = 4,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                             clk,
    input  logic                             arst_n,
    axil_mmio_bridge_if.slave                s_axi,
    output logic [N_SLOTS-1:0]               slot_cs,
    output logic [N_SLOTS-1:0]               slot_read,
    output logic [N_SLOTS-1:0]               slot_write,
    output logic [REG_ADDR_W-1:0]            slot_reg_addr,
    output logic [DATA_W-1:0]                slot_wr_data,
    output logic [DATA_W/8-1:0]              slot_wstrb,
    input  logic [N_SLOTS-1:0][DATA_W-1:0]   slot_rd_data,
    input  logic [N_SLOTS-1:0]               slot_done,
    input  logic [N_SLOTS-1:0]               slot_err
);
    localparam int SLOT_W = ADDR_W - REG_ADDR_W - 2;
    localparam int IDX_W  = $clog2(N_SLOTS);
    if (SLOT_W < IDX_W || N_SLOTS < 2 || TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_bad_cfg
        $error("axil_mmio_bridge: illegal parameter combination");
    end
    state_t                  state;
    axi_resp_t               resp;
    logic [1:0]              gnt;
    logic [IDX_W-1:0]        idx;
    logic [REG_ADDR_W-1:0]   reg_q;
    logic [DATA_W-1:0]       wdata_q, rdata_q;
    logic [DATA_W/8-1:0]     strb_q;
    logic                    bvalid, rvalid, acc, done, err, tmo, bad, unused;
    logic [ADDR_W-1:0]       gaddr;
    logic [SLOT_W-1:0]       gslot;
    logic [N_SLOTS-1:0]      oh;
    axil_rr_arb2 u_arb (
        .clk    (clk),
        .arst_n (arst_n),
        .en     (state == IDLE),
        .req    ({s_axi.arvalid, s_axi.awvalid & s_axi.wvalid}),
        .gnt    (gnt)
    );
    assign gaddr = gnt[0] ? s_axi.awaddr : s_axi.araddr;
    assign gslot = gaddr[ADDR_W-1:REG_ADDR_W+2];
    assign bad   = 32'(gslot) >= N_SLOTS;
    assign oh    = N_SLOTS'(1) << IDX_W'(gslot);
    assign acc   = state == WR_ACC || state == RD_ACC;
    assign done  = slot_done[idx];
    assign err   = slot_err[idx];
    assign unused = &{1'b0, s_axi.awprot, s_axi.arprot, gaddr[1:0]};
    assign s_axi.awready = gnt[0];
    assign s_axi.wready  = gnt[0];
    assign s_axi.arready = gnt[1];
    assign s_axi.bvalid  = bvalid;
    assign s_axi.rvalid  = rvalid;
    assign s_axi.bresp   = bvalid ? resp : AXI_RESP_OKAY;
    assign s_axi.rresp   = rvalid ? resp : AXI_RESP_OKAY;
    assign s_axi.rdata   = rdata_q;
    assign slot_reg_addr = acc ? reg_q : '0;
    assign slot_wr_data  = state == WR_ACC ? wdata_q : '0;
    assign slot_wstrb    = state == WR_ACC ? strb_q : '0;
`ifdef AXIL_MMIO_TIMEOUT_EN
    logic [15:0] cnt;
    always_ff @(posedge clk or negedge arst_n)
        if (!arst_n) cnt <= '0;
        else cnt <= acc ? cnt + 16'd1 : '0;
    assign tmo = acc && cnt == 16'(TIMEOUT_CYC - 1);
`else
    assign tmo = 1'b0;
`endif
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state      <= IDLE;
            resp       <= AXI_RESP_OKAY;
            idx        <= '0;
            reg_q      <= '0;
            wdata_q    <= '0;
            strb_q     <= '0;
            rdata_q    <= '0;
            bvalid     <= 1'b0;
            rvalid     <= 1'b0;
            slot_cs    <= '0;
            slot_read  <= '0;
            slot_write <= '0;
        end else begin
            case (state)
                IDLE: if (|gnt) begin
                    reg_q      <= gaddr[REG_ADDR_W+1:2];
                    idx        <= IDX_W'(gslot);
                    wdata_q    <= s_axi.wdata;
                    strb_q     <= s_axi.wstrb;
                    state      <= bad ? (gnt[0] ? WR_RESP : RD_RESP) : (gnt[0] ? WR_ACC : RD_ACC);
                    resp       <= bad ? AXI_RESP_DECERR : AXI_RESP_OKAY;
                    bvalid     <= bad & gnt[0];
                    rvalid     <= bad & gnt[1];
                    slot_cs    <= bad ? '0 : oh;
                    slot_write <= (bad | ~gnt[0]) ? '0 : oh;
                    slot_read  <= (bad | ~gnt[1]) ? '0 : oh;
                end
                WR_ACC, RD_ACC: begin
                    slot_write <= '0;
                    slot_read  <= '0;
                    // error beats done; a timeout only fires when neither arrived
                    if (done | err | tmo) begin
                        slot_cs <= '0;
                        resp    <= (done & ~err) ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
                        rdata_q <= (state == RD_ACC && done && !err) ? slot_rd_data[idx] : '0;
                        bvalid  <= state == WR_ACC;
                        rvalid  <= state == RD_ACC;
                        state   <= state == WR_ACC ? WR_RESP : RD_RESP;
                    end
                end
                WR_RESP: if (s_axi.bready) begin
                    bvalid <= 1'b0;
                    resp   <= AXI_RESP_OKAY;
                    state  <= IDLE;
                end
                RD_RESP: if (s_axi.rready) begin
                    rvalid  <= 1'b0;
                    resp    <= AXI_RESP_OKAY;
                    rdata_q <= '0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axil_mmio_bridge.sv
// tb_axil_mmio_bridge: directed scoreboard bench; a responder models the slots, a monitor checks responses.
module tb_axil_mmio_bridge;
    import mmio_pkg::*;
    logic clk = 1'b0;
    logic arst_n = 1'b0;
    always #5 clk = ~clk;
    axil_mmio_bridge_if #(.ADDR_W(12), .DATA_W(32)) bus ();
    logic [15:0]       slot_cs, slot_read, slot_write, slot_done, slot_err;
    logic [3:0]        slot_reg_addr, slot_wstrb;
    logic [31:0]       slot_wr_data;
    logic [15:0][31:0] slot_rd_data;
    axil_mmio_bridge #(
        .N_SLOTS(16), .ADDR_W(12), .REG_ADDR_W(4), .DATA_W(32), .TIMEOUT_CYC(8)
    ) dut (
        .clk           (clk),
        .arst_n        (arst_n),
        .s_axi         (bus),
        .slot_cs       (slot_cs),
        .slot_read     (slot_read),
        .slot_write    (slot_write),
        .slot_reg_addr (slot_reg_addr),
        .slot_wr_data  (slot_wr_data),
        .slot_wstrb    (slot_wstrb),
        .slot_rd_data  (slot_rd_data),
        .slot_done     (slot_done),
        .slot_err      (slot_err)
    );
    typedef struct {
        bit          rd;
        logic [1:0]  resp;
        logic [31:0] rdata;
        int          slot;
        logic [3:0]  rg;
        logic [31:0] wdata;
        logic [3:0]  strb;
    } exp_t;
    exp_t sb[$];
    int n_cmp = 0, n_bad = 0;
    int mode = 0, delay = 1, stall = 0;
    int acc_n = 0, acc_slot = -1, acc_kind = 0, pulses = 0;
    logic [3:0]  acc_reg = '0, acc_strb = '0;
    logic [31:0] acc_wdata = '0;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask
    function automatic void expw(logic [1:0] r, int s, logic [3:0] g, logic [31:0] d, logic [3:0] st);
        sb.push_back('{1'b0, r, 32'h0, s, g, d, st});
    endfunction
    function automatic void expr(logic [1:0] r, logic [31:0] d, int s, logic [3:0] g);
        sb.push_back('{1'b1, r, d, s, g, 32'h0, 4'h0});
    endfunction
    task automatic clr_acc();
        acc_n = 0; acc_slot = -1; acc_kind = 0; pulses = 0;
    endtask
    task automatic wr(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s);
        int n = 0;
        @(negedge clk);
        bus.awaddr = a; bus.awprot = 3'b010; bus.wdata = d; bus.wstrb = s;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1;
        #1;
        while (!bus.awready && n < 200) begin @(negedge clk); #1; n++; end
        if (n >= 200) begin n_cmp++; n_bad++; $display("FAIL write_accept timeout addr %h", a); end
        else chk("aw_w_ready_together", {30'h0, bus.awready, bus.wready}, 32'h3);
        @(posedge clk); #1;
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    endtask
    task automatic rd(input logic [11:0] a);
        int n = 0;
        @(negedge clk);
        bus.araddr = a; bus.arprot = 3'b001; bus.arvalid = 1'b1;
        #1;
        while (!bus.arready && n < 200) begin @(negedge clk); #1; n++; end
        if (n >= 200) begin n_cmp++; n_bad++; $display("FAIL read_accept timeout addr %h", a); end
        @(posedge clk); #1;
        bus.arvalid = 1'b0;
    endtask
    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 500) begin @(negedge clk); n++; end
        chk("scoreboard_drained", sb.size(), 0);
        sb.delete();
        @(negedge clk);
    endtask
    // slot responder: records the first ACC cycle, answers after `delay` cycles per `mode`
    initial begin
        int c;
        c = 0; slot_done = '0; slot_err = '0;
        forever begin
            @(negedge clk);
            if (!arst_n || slot_cs == '0) begin
                c = 0; slot_done = '0; slot_err = '0;
            end else begin
                if ((slot_write | slot_read) != '0) pulses++;
                if (c == 0) begin
                    acc_n++;
                    acc_slot = -2;
                    for (int s = 0; s < 16; s++) if (slot_cs == 16'(1) << s) acc_slot = s;
                    acc_kind = |slot_write ? 1 : |slot_read ? 2 : 0;
                    acc_reg = slot_reg_addr; acc_wdata = slot_wr_data; acc_strb = slot_wstrb;
                end
                c++;
                if (c >= delay && mode != 3) begin
                    slot_done = mode != 1 ? slot_cs : '0;
                    slot_err  = mode != 0 ? slot_cs : '0;
                end
            end
        end
    end
    // response monitor and scoreboard checker
    initial begin
        exp_t e;
        bus.bready = 1'b0; bus.rready = 1'b0;
        forever begin
            @(negedge clk);
            bus.bready = 1'b0; bus.rready = 1'b0;
            if (!arst_n || !(bus.bvalid || bus.rvalid)) continue;
            if (sb.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL unexpected_response bvalid=%b rvalid=%b", bus.bvalid, bus.rvalid);
                bus.bready = bus.bvalid; bus.rready = bus.rvalid;
            end else if (bus.rvalid && stall > 0) begin
                stall--;
                chk("rdata_stable", bus.rdata, sb[0].rdata);
                chk("rresp_stable", {30'h0, bus.rresp}, {30'h0, sb[0].resp});
            end else begin
                e = sb.pop_front();
                chk("kind_is_read", {31'h0, bus.rvalid}, {31'h0, e.rd});
                chk("resp", {30'h0, bus.rvalid ? bus.rresp : bus.bresp}, {30'h0, e.resp});
                if (e.rd) chk("rdata", bus.rdata, e.rdata);
                chk("slot_accesses", acc_n, e.slot < 0 ? 0 : 1);
                if (e.slot >= 0) begin
                    chk("slot_index", acc_slot, e.slot);
                    chk("slot_reg_addr", {28'h0, acc_reg}, {28'h0, e.rg});
                    chk("strobe_pulses", pulses, 1);
                    chk("access_dir", acc_kind, e.rd ? 2 : 1);
                    if (!e.rd) begin
                        chk("slot_wr_data", acc_wdata, e.wdata);
                        chk("slot_wstrb", {28'h0, acc_strb}, {28'h0, e.strb});
                    end
                end
                clr_acc();
                bus.bready = bus.bvalid; bus.rready = bus.rvalid;
            end
        end
    end
    initial begin
        #300000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end
    initial begin
        int n;
        bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0;
        bus.wvalid = 1'b0; bus.araddr = '0; bus.arprot = '0; bus.arvalid = 1'b0;
        for (int s = 0; s < 16; s++) slot_rd_data[s] = 32'hC0DE0000 | 32'(s);
        slot_rd_data[3] = 32'h12345678;
        repeat (3) @(negedge clk);
        chk("reset_bvalid", {31'h0, bus.bvalid}, 0);
        chk("reset_rvalid", {31'h0, bus.rvalid}, 0);
        chk("reset_slot_cs", {16'h0, slot_cs}, 0);
        chk("reset_rdata", bus.rdata, 0);
        arst_n = 1'b1;
        @(negedge clk);
        // simultaneous write+read twice: W, R, W, R
        expw(AXI_RESP_OKAY, 2, 4'd1, 32'hA5A50001, 4'h3);
        expr(AXI_RESP_OKAY, 32'hC0DE0004, 4, 4'd3);
        fork wr(12'h084, 32'hA5A50001, 4'h3); rd(12'h10C); join
        expw(AXI_RESP_OKAY, 7, 4'd0, 32'h0BADF00D, 4'hF);
        expr(AXI_RESP_OKAY, 32'hC0DE0009, 9, 4'd5);
        fork wr(12'h1C0, 32'h0BADF00D, 4'hF); rd(12'h254); join
        drain();
        delay = 3;
        expw(AXI_RESP_OKAY, 1, 4'd1, 32'hDEADBEEF, 4'hF);
        wr(12'h044, 32'hDEADBEEF, 4'hF);
        drain();
        delay = 1; stall = 5;
        expr(AXI_RESP_OKAY, 32'h12345678, 3, 4'd2);
        rd(12'h0C8);
        drain();
        expr(AXI_RESP_DECERR, 32'h0, -1, 4'd0);
        rd(12'h400);
        expw(AXI_RESP_DECERR, -1, 4'd0, 32'h0, 4'h0);
        wr(12'hFC0, 32'h55555555, 4'hF);
        drain();
        mode = 1;
        expw(AXI_RESP_SLVERR, 5, 4'd2, 32'h11112222, 4'h5);
        wr(12'h148, 32'h11112222, 4'h5);
        expr(AXI_RESP_SLVERR, 32'h0, 8, 4'd15);
        rd(12'h23C);
        drain();
        mode = 2;
        expr(AXI_RESP_SLVERR, 32'h0, 6, 4'd1);
        rd(12'h184);
        drain();
        mode = 0;
        expr(AXI_RESP_OKAY, 32'h12345678, 3, 4'd2);
        rd(12'h0CB);
        drain();
        mode = 3;
`ifdef AXIL_MMIO_TIMEOUT_EN
        expw(AXI_RESP_SLVERR, 2, 4'd0, 32'hCAFEF00D, 4'hF);
        wr(12'h080, 32'hCAFEF00D, 4'hF);
        drain();
`else
        wr(12'h080, 32'hCAFEF00D, 4'hF);
        repeat (100) @(negedge clk);
        chk("hang_slot_cs", {16'h0, slot_cs}, 32'h0004);
        chk("hang_bvalid", {31'h0, bus.bvalid}, 0);
        arst_n = 1'b0;
        @(negedge clk);
        arst_n = 1'b1;
        clr_acc();
        @(negedge clk);
`endif
        // write address without data is never accepted
        bus.awaddr = 12'h044; bus.awvalid = 1'b1; bus.wvalid = 1'b0;
        repeat (4) begin #1; chk("aw_alone_awready", {31'h0, bus.awready}, 0); @(negedge clk); end
        bus.awvalid = 1'b0;
        // after a timeout the last grant was a write, so the read now has priority
        mode = 0;
`ifdef AXIL_MMIO_TIMEOUT_EN
        expr(AXI_RESP_OKAY, 32'hC0DE000A, 10, 4'd0);
        expw(AXI_RESP_OKAY, 11, 4'd7, 32'h77778888, 4'hC);
`else
        expw(AXI_RESP_OKAY, 11, 4'd7, 32'h77778888, 4'hC);
        expr(AXI_RESP_OKAY, 32'hC0DE000A, 10, 4'd0);
`endif
        fork wr(12'h2DC, 32'h77778888, 4'hC); rd(12'h280); join
        drain();
        // reset during RD_ACC
        mode = 3;
        rd(12'h0C4);
        chk("rd_acc_slot_cs", {16'h0, slot_cs}, 32'h0008);
        @(negedge clk);
        arst_n = 1'b0;
        @(posedge clk); #1;
        chk("rst_slot_cs", {16'h0, slot_cs}, 0);
        chk("rst_slot_read", {16'h0, slot_read}, 0);
        chk("rst_slot_reg_addr", {28'h0, slot_reg_addr}, 0);
        chk("rst_rvalid", {31'h0, bus.rvalid}, 0);
        chk("rst_rdata", bus.rdata, 0);
        chk("rst_arready", {31'h0, bus.arready}, 0);
        @(negedge clk);
        arst_n = 1'b1;
        clr_acc();
        mode = 0;
        @(negedge clk);
        expr(AXI_RESP_OKAY, 32'h12345678, 3, 4'd1);
        rd(12'h0C4);
        drain();
        n = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
